// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory opcodes and the memory-stage state encoding.
package lc3_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_PTR    = 2'd1,
    MS_ACCESS = 2'd2,
    MS_DONE   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Classifies an LC-3 opcode as load/store and direct/indirect.
// Purely combinational, no latency, no flow control.
module mem_op_decode
  import lc3_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_ind
);

  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_ind   = 1'b0;
    case (op)
      OP_LD, OP_LDR: is_mem = 1'b1;
      OP_LDI:        begin is_mem = 1'b1; is_ind = 1'b1; end
      OP_ST, OP_STR: begin is_mem = 1'b1; is_store = 1'b1; end
      OP_STI:        begin is_mem = 1'b1; is_store = 1'b1; is_ind = 1'b1; end
      default:       ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory-access stage sequencer: one memory transaction for direct ops, two for indirect.
// Latency 3 cycles direct / 4 indirect plus memory waits; stalls upstream until the op completes.
module mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic [3:0]        m_op,
  input  logic [DATA_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [1:0]        mem_state
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q, ptr_q, ld_data_q;
  logic              is_store_q, is_ind_q;
  logic              dec_mem, dec_store, dec_ind;
  logic              accept;

  mem_op_decode u_dec (
    .op       (m_op),
    .is_mem   (dec_mem),
    .is_store (dec_store),
    .is_ind   (dec_ind)
  );

  assign accept = (state_q == MS_IDLE) && m_valid && dec_mem;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    ld_valid  = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = dec_ind ? MS_PTR : MS_ACCESS;
        end
      end
      MS_PTR: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ready) state_d = MS_ACCESS;
      end
      MS_ACCESS: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = is_ind_q ? ptr_q : addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) state_d = MS_DONE;
      end
      MS_DONE: begin
        // stall drops here so the pipeline register advances past the finished op
        ld_valid = !is_store_q;
        state_d  = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MS_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      ld_data_q  <= '0;
      is_store_q <= 1'b0;
      is_ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= m_addr;
        wdata_q    <= m_wdata;
        is_store_q <= dec_store;
        is_ind_q   <= dec_ind;
      end
      if (state_q == MS_PTR && mem_ready)
        ptr_q <= mem_rdata;
      if (state_q == MS_ACCESS && mem_ready && !is_store_q)
        ld_data_q <= mem_rdata;
    end
  end

  assign ld_data   = ld_data_q;
  assign mem_state = state_q;

endmodule
